// File: rtl/uop_dispatch_queue_if.sv
// Handshake bundle between the microcode stage (push side), the dispatch queue,
// and the rename/dispatch stage (pop side).
interface uop_dispatch_queue_if #(
  parameter int WIDTH     = 32,
  parameter int IN_LANES  = 2,
  parameter int OUT_LANES = 2
);
  logic [IN_LANES-1:0]              in_valid;
  logic [IN_LANES*WIDTH-1:0]        in_data;
  logic                             in_ready;
  logic [OUT_LANES-1:0]             out_valid;
  logic [OUT_LANES*WIDTH-1:0]       out_data;
  logic [$clog2(OUT_LANES+1)-1:0]   out_pop;

  modport master (
    output in_valid, in_data, out_pop,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_pop,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/uop_dispatch_queue.sv
// Multi-lane micro-op FIFO between microcode and rename/dispatch: superscalar
// push/pop, flush, occupancy and sticky overflow reporting.
module uop_dispatch_queue #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int IN_LANES    = 2,
  parameter int OUT_LANES   = 2,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  uop_dispatch_queue_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_almost_full,
  output logic                         o_overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(IN_LANES+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow_err;

  logic [LW-1:0]    w_push_cnt;
  logic             w_run;
  logic             w_in_ready;
  logic [LW-1:0]    w_push_acc;
  logic [CW-1:0]    w_pop_lim;
  logic [CW-1:0]    w_pop_req;
  logic [CW-1:0]    w_pop_q;
  logic [CW-1:0]    w_count_next;
  logic [PW-1:0]    w_wr_idx [IN_LANES];
  logic [PW-1:0]    w_rd_idx [OUT_LANES];

  // Contiguous valid lanes from lane 0; anything after the first gap is ignored.
  always_comb begin
    w_push_cnt = '0;
    w_run      = 1'b1;
    for (int i = 0; i < IN_LANES; i++) begin
      if (w_run && bus.in_valid[i]) begin
        w_push_cnt = w_push_cnt + LW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Ready uses only registered occupancy, so out_pop never reaches in_ready.
  always_comb begin
    w_in_ready   = (r_count <= CW'(DEPTH - IN_LANES));
    w_push_acc   = (w_in_ready && !i_flush) ? w_push_cnt : '0;
    w_pop_lim    = (r_count < CW'(OUT_LANES)) ? r_count : CW'(OUT_LANES);
    w_pop_req    = CW'(bus.out_pop);
    w_pop_q      = (w_pop_req < w_pop_lim) ? w_pop_req : w_pop_lim;
    w_count_next = r_count - w_pop_q + CW'(w_push_acc);
  end

  // Per-lane slot indices; PW-bit arithmetic wraps modulo DEPTH.
  always_comb begin
    for (int i = 0; i < IN_LANES; i++) begin
      w_wr_idx[i] = r_wr_ptr + PW'(i);
    end
    for (int j = 0; j < OUT_LANES; j++) begin
      w_rd_idx[j] = r_rd_ptr + PW'(j);
    end
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_err <= r_overflow_err;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push_acc);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop_q);
      r_count  <= w_count_next;
      if (!w_in_ready && (w_push_cnt != '0)) begin
        r_overflow_err <= 1'b1;
      end else begin
        r_overflow_err <= r_overflow_err;
      end
    end
  end

  // Storage array is intentionally left uncleared by reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < IN_LANES; i++) begin
      if (!i_reset && (LW'(i) < w_push_acc)) begin
        r_mem[w_wr_idx[i]] <= bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Zero-latency read of the oldest OUT_LANES entries.
  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      bus.out_valid[j]                 = (r_count > CW'(j));
      bus.out_data[j*WIDTH +: WIDTH]   = r_mem[w_rd_idx[j]];
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign o_count          = r_count;
  assign o_almost_full    = (r_count >= CW'(AFULL_LEVEL));
  assign o_overflow_err   = r_overflow_err;
endmodule
